// File: rtl/game_pkg.sv
// Shared definitions for the game-control blocks.
//   game_state_t     : controller state encoding (IDLE/PLAY/CRASH/OVER)
//   LIVES_DEF        : default number of lives loaded at game start
//   HOLD_FRAMES_DEF  : default frame ticks spent in the crash hold
//   BLINK_FRAMES_DEF : default frame ticks per half-period of the crash blink
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int unsigned LIVES_DEF        = 3;
  localparam int unsigned HOLD_FRAMES_DEF  = 120;
  localparam int unsigned BLINK_FRAMES_DEF = 15;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a synchronous level (e.g. a debounced button).
//   clk   : system clock
//   reset : asynchronous, active-high reset (previous level cleared to 0)
//   d     : input level
//   pulse : high for the one clk in which d is high and was low on the previous clk
// A level held high produces exactly one pulse.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/crash_game_ctrl.sv
// Game-state controller driving the crash-text overlay enable.
// Acts on frame boundaries: a collision seen during a frame in PLAY causes a
// crash at the next frame_tick, the crash text blinks for HOLD_FRAMES ticks,
// then the game respawns (restart pulse) or enters the game-over hold.
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   frame_tick   : one-clk pulse per video frame
//   collision    : per-pixel player/obstacle overlap
//   btn_start    : debounced start-button level
//   crash_en     : crash-text overlay enable (blinks in CRASH, steady in OVER)
//   game_run     : high while objects may move / score may advance
//   game_restart : one-clk pulse to reload positions and score
//   lives        : remaining lives
//   game_over    : high in OVER
// All outputs are registered.
module crash_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES        = LIVES_DEF,
  parameter int unsigned HOLD_FRAMES  = HOLD_FRAMES_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       btn_start,
  output logic       crash_en,
  output logic       game_run,
  output logic       game_restart,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  game_state_t   state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          latch_q, latch_d;
  logic          crash_en_q, crash_en_d;
  logic          game_run_q, game_run_d;
  logic          game_restart_q, game_restart_d;
  logic          game_over_q, game_over_d;

  logic start_edge;
  logic hit;

  edge_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .d     (btn_start),
    .pulse (start_edge)
  );

  // A collision in the same clk as frame_tick still counts for that frame.
  assign hit = latch_q | collision;

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    frame_cnt_d    = frame_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    latch_d        = latch_q;
    game_restart_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d        = PLAY;
          lives_d        = LIVES_INIT;
          latch_d        = 1'b0;
          game_restart_d = 1'b1;
        end
      end

      PLAY: begin
        latch_d = latch_q | collision;
        if (frame_tick && hit) begin
          state_d       = CRASH;
          lives_d       = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          frame_cnt_d   = '0;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b0;
          latch_d       = 1'b0;
        end
      end

      CRASH: begin
        if (frame_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            // Counters cleared on exit so they never wrap.
            frame_cnt_d   = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
            latch_d       = 1'b0;
            if (lives_q == 2'd0) begin
              state_d = OVER;
            end else begin
              state_d        = PLAY;
              game_restart_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
            // Phase bit tracks parity of frame_cnt / BLINK_FRAMES without a divider.
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end

      OVER: begin
        if (start_edge) begin
          state_d        = PLAY;
          lives_d        = LIVES_INIT;
          latch_d        = 1'b0;
          game_restart_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it when registered.
    game_run_d  = (state_d == PLAY);
    game_over_d = (state_d == OVER);
    crash_en_d  = (state_d == OVER) || ((state_d == CRASH) && !blink_phase_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      lives_q        <= LIVES_INIT;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      latch_q        <= 1'b0;
      crash_en_q     <= 1'b0;
      game_run_q     <= 1'b0;
      game_restart_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      latch_q        <= latch_d;
      crash_en_q     <= crash_en_d;
      game_run_q     <= game_run_d;
      game_restart_q <= game_restart_d;
      game_over_q    <= game_over_d;
    end
  end

  assign crash_en     = crash_en_q;
  assign game_run     = game_run_q;
  assign game_restart = game_restart_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_crash_game_ctrl.sv
// Directed bench for crash_game_ctrl with LIVES=2, HOLD_FRAMES=4, BLINK_FRAMES=1
// and a frame_tick every 10 clk.
module tb_crash_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       collision;
  logic       btn_start;
  logic       crash_en;
  logic       game_run;
  logic       game_restart;
  logic [1:0] lives;
  logic       game_over;

  crash_game_ctrl #(
    .LIVES        (2),
    .HOLD_FRAMES  (4),
    .BLINK_FRAMES (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .collision    (collision),
    .btn_start    (btn_start),
    .crash_en     (crash_en),
    .game_run     (game_run),
    .game_restart (game_restart),
    .lives        (lives),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic        col;
    logic        btn;
    logic        ce;
    logic        run;
    logic        rs;
    logic [1:0]  lv;
    logic        ov;
    int unsigned rcnt;
  } vec_t;

  vec_t vecs[20];

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  int fphase = 0;
  int unsigned restart_cnt = 0;
  logic prev_restart = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // One clk with frame_tick on every 10th cycle; outputs sampled 1 ns after the edge.
  task automatic step(input logic col, input logic btn);
    frame_tick = (fphase == 9);
    collision  = col;
    btn_start  = btn;
    @(posedge clk);
    #1;
    fphase = (fphase + 1) % 10;
    if (game_restart) restart_cnt++;
    if (game_restart && prev_restart) chk("restart_width", -1, 32'(game_restart), 32'd0);
    prev_restart = game_restart;
  endtask

  task automatic chk_outs(input int idx, input logic ce, input logic run, input logic rs,
                          input logic [1:0] lv, input logic ov);
    chk("crash_en",     idx, 32'(crash_en),     32'(ce));
    chk("game_run",     idx, 32'(game_run),     32'(run));
    chk("game_restart", idx, 32'(game_restart), 32'(rs));
    chk("lives",        idx, 32'(lives),        32'(lv));
    chk("game_over",    idx, 32'(game_over),    32'(ov));
  endtask

  initial begin
    //                n   col btn  ce run rs lv    ov rcnt
    // collision in IDLE is ignored
    vecs[0]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 0};
    // held start: one restart, PLAY
    vecs[1]  = '{50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1};
    vecs[2]  = '{ 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1};
    // mid-frame collision pulse, crash waits for the tick
    vecs[3]  = '{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1};
    vecs[4]  = '{ 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1};
    vecs[5]  = '{ 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1};
    // CRASH with collision held and start edges: blink 0,1,0 then respawn
    vecs[6]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1};
    vecs[7]  = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1};
    vecs[8]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1};
    vecs[9]  = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2};
    // latch was cleared on PLAY entry: no crash at the next tick
    vecs[10] = '{10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2};
    vecs[11] = '{ 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2};
    // collision coincident with the tick crashes at that tick
    vecs[12] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2};
    vecs[13] = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2};
    vecs[14] = '{10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2};
    vecs[15] = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2};
    // no lives left: OVER with steady crash_en
    vecs[16] = '{10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2};
    vecs[17] = '{20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2};
    // start from OVER: PLAY, lives reloaded, single restart pulse
    vecs[18] = '{ 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 3};
    vecs[19] = '{ 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3};

    reset      = 1'b1;
    frame_tick = 1'b0;
    collision  = 1'b0;
    btn_start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs(-1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    reset  = 1'b0;
    fphase = 0;

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++) step(vecs[i].col, vecs[i].btn);
      n_vec++;
      chk_outs(i, vecs[i].ce, vecs[i].run, vecs[i].rs, vecs[i].lv, vecs[i].ov);
      chk("restart_count", i, restart_cnt, vecs[i].rcnt);
    end

    // Into CRASH again (fphase is 2: eight steps reach the tick), then async reset.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    n_vec++;
    chk_outs(100, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    chk_outs(101, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
    n_vec++;
    chk_outs(102, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b0, 1'b1);
    n_vec++;
    chk_outs(103, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crash_game_ctrl.md
Name: crash_game_ctrl

Overview:
- Game-state controller sitting directly upstream of the "DIED!" crash-text overlay; produces its `crash_en` enable.
- Watches the per-pixel collision flag from the object/obstacle renderer and acts only on frame boundaries.
- Freezes gameplay on a crash, blinks the crash text for a hold period, and manages a lives counter.
- Issues restart pulses to the position/scroll logic and reaches a game-over hold that waits for the start button.

Parameters:
- LIVES, 3: lives loaded at game start; legal range 1..3, since the `lives` port is 2 bits.
- HOLD_FRAMES, 120: frame ticks spent in CRASH before respawn or game over (2 s at 60 Hz); must be ≥1.
- BLINK_FRAMES, 15: frame ticks per half-period of the `crash_en` blink in CRASH; must be ≥1.

Ports:
- clk  in  1  system clock (pixel-domain clock shared with the video path)
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame (from the VGA sync, start of vertical blank)
- collision  in  1  per-pixel overlap of player and obstacle; may pulse on any clk during active video
- btn_start  in  1  debounced start-button level
- crash_en  out  1  enable for the crash-text overlay
- game_run  out  1  high while objects may move and score may advance
- game_restart  out  1  one-clk pulse: reload player/obstacle positions and score
- lives  out  2  remaining lives
- game_over  out  1  high in OVER state

Behaviour:
- All outputs are registered.
- Async reset values:
  - state = IDLE, lives = LIVES.
  - crash_en, game_run, game_restart, game_over = 0.
  - Frame counter = 0, collision latch = 0, btn_q = 0.
- Reset asserted mid-operation returns to IDLE immediately, whatever the current state.
- Start edge: `start_edge = btn_start & ~btn_q`. `btn_q` is registered every clk. A held button produces exactly one edge.
- Collision latch:
  - Set on any clk where collision = 1 and state = PLAY.
  - Cleared on every transition into PLAY.
  - Collision is ignored in all other states.
- hit = latch | collision. This means a collision arriving in the same cycle as frame_tick counts for that frame.
- IDLE:
  - Outputs: game_run = 0, crash_en = 0.
  - On start_edge: next cycle state = PLAY, lives = LIVES, game_restart = 1 for exactly one clk.
- PLAY:
  - Outputs: game_run = 1, crash_en = 0.
  - On frame_tick & hit: next cycle state = CRASH, game_run = 0, lives = lives − 1 (saturating at 0), frame counter = 0, latch cleared.
  - frame_tick without hit: no change.
- CRASH:
  - Outputs: game_run = 0. crash_en = 1 while (frame_cnt / BLINK_FRAMES) is even, else 0. crash_en = 1 on the first cycle in CRASH.
  - Each frame_tick increments frame_cnt.
  - On the frame_tick where frame_cnt == HOLD_FRAMES−1:
    - if lives == 0 → OVER;
    - else → PLAY with game_restart pulsed for one clk, frame_cnt = 0, latch cleared.
  - start_edge is ignored in CRASH.
- OVER:
  - Outputs: game_over = 1, crash_en = 1 steady, game_run = 0.
  - On start_edge: → PLAY, lives = LIVES, game_restart pulse, game_over = 0, latch cleared.
- game_restart is never high for more than one consecutive clk. It is never asserted in the same cycle as crash_en = 1 after leaving CRASH/OVER.
- frame_cnt width is $clog2(HOLD_FRAMES+1). It never wraps, because it is cleared on exit from CRASH.
- The blink index uses a division-free implementation: a separate blink counter cleared every BLINK_FRAMES ticks that toggles a phase bit.

Decomposition:
- Shared package `game_pkg`:
  - state encoding `game_state_t` (IDLE = 0, PLAY = 1, CRASH = 2, OVER = 3);
  - default constants LIVES_DEF, HOLD_FRAMES_DEF, BLINK_FRAMES_DEF, used by other game blocks.
- One sub-module `edge_rise`: registered rising-edge detector (clk, reset, d → pulse). It is reused for other buttons.
- FSM, counters and latch stay in the top.

Test Plan:
All scenarios use LIVES = 2, HOLD_FRAMES = 4, BLINK_FRAMES = 1, with frame_tick every 10 clk.
1. Reset then btn_start held high for 50 clk → exactly one game_restart pulse, state PLAY, lives = 2, game_run = 1, crash_en = 0.
2. In PLAY, collision pulse 1 clk mid-frame → at the next frame_tick: lives = 1, game_run = 0; crash_en pattern per frame 1, 0, 1, 0; after the 4th tick, game_restart pulse and PLAY again.
3. collision and frame_tick in the same clk → crash taken at that tick, not one frame later.
4. Second crash with lives = 1 → lives = 0; after 4 ticks: OVER, game_over = 1, crash_en = 1 steady; start_edge → PLAY, lives = 2, game_restart pulse.
5. collision asserted throughout CRASH and IDLE, and start_edge during CRASH → no extra life loss, no state change; latch clear upon PLAY entry (no immediate crash at the first tick without a new collision).
6. Assert reset mid-CRASH (async, between clk edges) → outputs go to reset values immediately; IDLE after release.
